apb_slave_regif: RTL and testbench

Parametrised APB slave front-end for the Timer-APB register bank. It adds configurable wait states, address decode, byte strobes and error response (pslverr) to the plain psel/penable strobe decode. It sits between the APB bus and the timer register file. It emits one-cycle, indexed read/write strobes and returns read data muxed from a flattened register bus.

---
 rtl/apb_slave_regif.sv | 123 ++++++++++++
 tb/tb_apb_slave_regif.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regif.sv
// APB slave front-end for the Timer-APB register bank: wait states, address
// decode, read-only protection and one-cycle indexed strobes to the register file.
module apb_slave_regif #(
  parameter int unsigned          ADDR_W      = 12,
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          NUM_REGS    = 8,
  parameter int unsigned          WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  input  logic [DATA_W/8-1:0]          pstrb,
  output logic                         pready,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pslverr,
  output logic                         wr_en,
  output logic                         rd_en,
  output logic [$clog2(NUM_REGS)-1:0]  reg_idx,
  output logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W/8-1:0]          wr_strb,
  input  logic [NUM_REGS*DATA_W-1:0]   rd_data_bus
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFS    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned WORD_W = ADDR_W - OFS;
  localparam int unsigned CMP_W  = (WORD_W > 32) ? WORD_W : 32;
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READY
  } state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;

  logic [WORD_W-1:0]   word;
  logic [IDX_W-1:0]    idx;
  logic                misaligned;
  logic                out_of_range;
  logic                ro_hit;
  logic                err;
  logic                xfer;
  logic [DATA_W-1:0]   rd_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (psel && !penable) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            if (WAIT_CYCLES == 0) begin
              state_q <= S_READY;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (!psel) begin
            state_q <= S_IDLE;
          end else if (cnt_q == '0) begin
            state_q <= S_READY;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_READY: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Decode works on the latched address so the response cannot shift mid-transfer.
  assign word         = addr_q[ADDR_W-1:OFS];
  assign idx          = word[IDX_W-1:0];
  assign misaligned   = (addr_q[OFS-1:0] != '0);
  assign out_of_range = (CMP_W'(word) >= CMP_W'(NUM_REGS));
  assign ro_hit       = write_q && !out_of_range && RO_MASK[idx];
  assign err          = misaligned || out_of_range || ro_hit;

  assign xfer    = (state_q == S_READY) && psel && penable;
  assign pready  = xfer;
  assign pslverr = xfer && err;
  assign wr_en   = xfer && write_q && !err;
  assign rd_en   = xfer && !write_q && !err;

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) rd_word = rd_data_bus[i*DATA_W +: DATA_W];
    end
  end

  assign prdata  = rd_en ? rd_word : '0;
  assign reg_idx = idx;
  assign wr_data = wdata_q;
  assign wr_strb = strb_q;

endmodule

// File: tb/tb_apb_slave_regif.sv
// Bench for apb_slave_regif: one 2-wait-state and one zero-wait instance, directed
// scenarios plus random transfers, checked every cycle against a transaction-level model.
module tb_apb_slave_regif;

  localparam logic [7:0] RO = 8'h80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         rst_n_v, psel_v, penable_v, pwrite_v;
  logic [1:0][11:0]   paddr_v;
  logic [1:0][31:0]   pwdata_v;
  logic [1:0][3:0]    pstrb_v;
  logic [1:0]         pready_v, pslverr_v, wr_en_v, rd_en_v;
  logic [1:0][31:0]   prdata_v, wr_data_v;
  logic [1:0][2:0]    reg_idx_v;
  logic [1:0][3:0]    wr_strb_v;
  logic [1:0][255:0]  bus_v;

  logic [31:0] regs [2][8];

  logic [1:0]         exp_pready, exp_slverr, exp_wr, exp_rd;
  logic [1:0][31:0]   exp_prdata, exp_wdata;
  logic [1:0][2:0]    exp_idx;
  logic [1:0][3:0]    exp_wstrb;

  int  n_checks = 0;
  int  n_err    = 0;
  bit  chk_en   = 1'b0;
  int  n_wr [2];
  int  n_rd [2];

  apb_slave_regif #(.ADDR_W(12), .DATA_W(32), .NUM_REGS(8), .WAIT_CYCLES(2), .RO_MASK(8'h80)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n_v[0]), .psel(psel_v[0]), .penable(penable_v[0]), .pwrite(pwrite_v[0]),
    .paddr(paddr_v[0]), .pwdata(pwdata_v[0]), .pstrb(pstrb_v[0]), .pready(pready_v[0]),
    .prdata(prdata_v[0]), .pslverr(pslverr_v[0]), .wr_en(wr_en_v[0]), .rd_en(rd_en_v[0]),
    .reg_idx(reg_idx_v[0]), .wr_data(wr_data_v[0]), .wr_strb(wr_strb_v[0]), .rd_data_bus(bus_v[0])
  );

  apb_slave_regif #(.ADDR_W(12), .DATA_W(32), .NUM_REGS(8), .WAIT_CYCLES(0), .RO_MASK(8'h80)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n_v[1]), .psel(psel_v[1]), .penable(penable_v[1]), .pwrite(pwrite_v[1]),
    .paddr(paddr_v[1]), .pwdata(pwdata_v[1]), .pstrb(pstrb_v[1]), .pready(pready_v[1]),
    .prdata(prdata_v[1]), .pslverr(pslverr_v[1]), .wr_en(wr_en_v[1]), .rd_en(rd_en_v[1]),
    .reg_idx(reg_idx_v[1]), .wr_data(wr_data_v[1]), .wr_strb(wr_strb_v[1]), .rd_data_bus(bus_v[1])
  );

  always_comb begin
    bus_v = '0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) bus_v[d][i*32 +: 32] = regs[d][i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("pready%0d", d),  32'(pready_v[d]),  32'(exp_pready[d]));
        chk($sformatf("pslverr%0d", d), 32'(pslverr_v[d]), 32'(exp_slverr[d]));
        chk($sformatf("wr_en%0d", d),   32'(wr_en_v[d]),   32'(exp_wr[d]));
        chk($sformatf("rd_en%0d", d),   32'(rd_en_v[d]),   32'(exp_rd[d]));
        chk($sformatf("prdata%0d", d),  prdata_v[d],       exp_prdata[d]);
        chk($sformatf("reg_idx%0d", d), 32'(reg_idx_v[d]), 32'(exp_idx[d]));
        chk($sformatf("wr_data%0d", d), wr_data_v[d],      exp_wdata[d]);
        chk($sformatf("wr_strb%0d", d), 32'(wr_strb_v[d]), 32'(exp_wstrb[d]));
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wr_en_v[d]) n_wr[d]++;
      if (rd_en_v[d]) n_rd[d]++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit model_err(input logic [11:0] a, input logic w);
    int wi;
    wi = int'(a) / 4;
    if (int'(a) % 4 != 0) return 1'b1;
    if (wi >= 8) return 1'b1;
    return w && RO[wi];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse(input int d);
    exp_pready[d] = 1'b0; exp_slverr[d] = 1'b0; exp_wr[d] = 1'b0; exp_rd[d] = 1'b0;
    exp_prdata[d] = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One APB transfer on instance d; drop_k/rst_k pick the access cycle (0 = T1) for an abort.
  task automatic xfer(input int d, input logic [11:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, input int drop_k, input int rst_k,
                      output int rdy_t, output logic [31:0] o_prdata, output logic o_err,
                      output logic o_wr, output logic o_rd, output logic [2:0] o_idx,
                      output logic [31:0] o_wdata);
    int  wc, wi;
    bit  e, stop;
    wc = (d == 0) ? 2 : 0;
    wi = int'(a) / 4;
    e  = model_err(a, w);
    rdy_t = -1; o_prdata = '0; o_err = 1'b0; o_wr = 1'b0; o_rd = 1'b0; o_idx = '0; o_wdata = '0;
    psel_v[d] = 1'b1; penable_v[d] = 1'b0; paddr_v[d] = a; pwrite_v[d] = w;
    pwdata_v[d] = wd; pstrb_v[d] = st;
    clr_pulse(d);
    step();
    exp_idx[d] = 3'(wi % 8); exp_wdata[d] = wd; exp_wstrb[d] = st;
    penable_v[d] = 1'b1;
    stop = 1'b0;
    for (int k = 0; k <= wc && !stop; k++) begin
      if (k == rst_k) begin
        rst_n_v[d] = 1'b0; psel_v[d] = 1'b0; penable_v[d] = 1'b0;
        clr_pulse(d);
        exp_idx[d] = '0; exp_wdata[d] = '0; exp_wstrb[d] = '0;
        #1;
        chk("rst_async_pready", 32'(pready_v[d]), 32'd0);
        chk("rst_async_rd_en", 32'(rd_en_v[d]), 32'd0);
        chk("rst_async_prdata", prdata_v[d], 32'd0);
        chk("rst_async_reg_idx", 32'(reg_idx_v[d]), 32'd0);
        chk("rst_async_wr_data", wr_data_v[d], 32'd0);
        @(negedge clk);
        #1;
        rst_n_v[d] = 1'b1;
        step();
        stop = 1'b1;
      end else if (k == drop_k) begin
        psel_v[d] = 1'b0; penable_v[d] = 1'b0;
        clr_pulse(d);
        step();
        stop = 1'b1;
      end else begin
        if (k == wc) begin
          exp_pready[d] = 1'b1;
          exp_slverr[d] = e;
          exp_wr[d]     = w && !e;
          exp_rd[d]     = !w && !e;
          exp_prdata[d] = (!w && !e) ? regs[d][wi] : 32'd0;
        end else begin
          clr_pulse(d);
        end
        @(negedge clk);
        if (pready_v[d] && rdy_t < 0) begin
          rdy_t = k + 1; o_prdata = prdata_v[d]; o_err = pslverr_v[d];
          o_wr = wr_en_v[d]; o_rd = rd_en_v[d]; o_idx = reg_idx_v[d]; o_wdata = wr_data_v[d];
        end
        @(posedge clk);
        if (k == wc && w && !e) begin
          for (int b = 0; b < 4; b++)
            if (st[b]) regs[d][wi][b*8 +: 8] = wd[b*8 +: 8];
        end
        #1;
      end
    end
    psel_v[d] = 1'b0; penable_v[d] = 1'b0;
    clr_pulse(d);
  endtask

  initial begin
    int rt, cnt0, cnt1, wc, drop, gap;
    logic [31:0] od, owd;
    logic oe, ow, orr, w;
    logic [2:0] oi;
    logic [11:0] a;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) regs[d][i] = $urandom;
      rst_n_v[d] = 1'b0; psel_v[d] = 1'b0; penable_v[d] = 1'b0; pwrite_v[d] = 1'b0;
      paddr_v[d] = '0; pwdata_v[d] = '0; pstrb_v[d] = '0;
      clr_pulse(d);
      exp_idx[d] = '0; exp_wdata[d] = '0; exp_wstrb[d] = '0;
      n_wr[d] = 0; n_rd[d] = 0;
    end
    regs[0][2] = 32'h1234_5678;
    chk_en = 1'b1;
    idle(3);
    chk("reset_pready", 32'(pready_v[0]), 32'd0);
    chk("reset_wr_data", wr_data_v[0], 32'd0);
    rst_n_v = 2'b11;
    idle(2);

    cnt0 = n_wr[0];
    xfer(0, 12'h004, 1'b1, 32'hA5A5_0001, 4'hF, -1, -1, rt, od, oe, ow, orr, oi, owd);
    chk("w1_latency", 32'(rt), 32'd3);
    chk("w1_wr_en", 32'(ow), 32'd1);
    chk("w1_reg_idx", 32'(oi), 32'd1);
    chk("w1_wr_data", owd, 32'hA5A5_0001);
    chk("w1_pslverr", 32'(oe), 32'd0);
    idle(2);
    chk("w1_one_strobe", 32'(n_wr[0] - cnt0), 32'd1);
    chk("w1_wr_data_hold", wr_data_v[0], 32'hA5A5_0001);

    xfer(0, 12'h008, 1'b0, 32'h0, 4'h0, -1, -1, rt, od, oe, ow, orr, oi, owd);
    chk("r2_latency", 32'(rt), 32'd3);
    chk("r2_prdata", od, 32'h1234_5678);
    chk("r2_rd_en", 32'(orr), 32'd1);
    @(negedge clk);
    chk("r2_next_prdata", prdata_v[0], 32'd0);
    step();

    xfer(0, 12'h01C, 1'b1, 32'hDEAD_BEEF, 4'hF, -1, -1, rt, od, oe, ow, orr, oi, owd);
    chk("err_ro_slverr", 32'(oe), 32'd1);
    chk("err_ro_wr_en", 32'(ow), 32'd0);
    xfer(0, 12'h020, 1'b0, 32'h0, 4'h0, -1, -1, rt, od, oe, ow, orr, oi, owd);
    chk("err_oor_slverr", 32'(oe), 32'd1);
    chk("err_oor_prdata", od, 32'd0);
    chk("err_oor_rd_en", 32'(orr), 32'd0);
    xfer(0, 12'h006, 1'b0, 32'h0, 4'h0, -1, -1, rt, od, oe, ow, orr, oi, owd);
    chk("err_mis_slverr", 32'(oe), 32'd1);
    chk("err_mis_rd_en", 32'(orr), 32'd0);
    idle(1);

    cnt0 = n_wr[1]; cnt1 = n_rd[1];
    xfer(1, 12'h000, 1'b1, 32'h0000_00AA, 4'hF, -1, -1, rt, od, oe, ow, orr, oi, owd);
    chk("b2b0_latency", 32'(rt), 32'd1);
    chk("b2b0_reg_idx", 32'(oi), 32'd0);
    xfer(1, 12'h004, 1'b0, 32'h0, 4'h0, -1, -1, rt, od, oe, ow, orr, oi, owd);
    chk("b2b1_latency", 32'(rt), 32'd1);
    chk("b2b1_reg_idx", 32'(oi), 32'd1);
    xfer(1, 12'h008, 1'b1, 32'h0000_00CC, 4'hF, -1, -1, rt, od, oe, ow, orr, oi, owd);
    chk("b2b2_latency", 32'(rt), 32'd1);
    chk("b2b2_reg_idx", 32'(oi), 32'd2);
    idle(2);
    chk("b2b_strobes", 32'((n_wr[1] - cnt0) + (n_rd[1] - cnt1)), 32'd3);

    cnt0 = n_wr[0];
    xfer(0, 12'h00C, 1'b1, 32'h5555_AAAA, 4'hF, 1, -1, rt, od, oe, ow, orr, oi, owd);
    idle(3);
    chk("drop_no_pready", 32'(rt + 1), 32'd0);
    chk("drop_no_wr_en", 32'(n_wr[0] - cnt0), 32'd0);
    xfer(0, 12'h00C, 1'b0, 32'h0, 4'h0, -1, -1, rt, od, oe, ow, orr, oi, owd);
    chk("drop_read_latency", 32'(rt), 32'd3);
    chk("drop_read_rd_en", 32'(orr), 32'd1);

    cnt1 = n_rd[0];
    xfer(0, 12'h010, 1'b0, 32'h0, 4'h0, -1, 1, rt, od, oe, ow, orr, oi, owd);
    idle(2);
    chk("rst_no_rd_en", 32'(n_rd[0] - cnt1), 32'd0);
    xfer(0, 12'h008, 1'b0, 32'h0, 4'h0, -1, -1, rt, od, oe, ow, orr, oi, owd);
    chk("rst_after_latency", 32'(rt), 32'd3);
    chk("rst_after_prdata", od, 32'h1234_5678);

    for (int n = 0; n < 300; n++) begin
      int dsel, kind;
      dsel = int'($urandom_range(0, 1));
      wc   = (dsel == 0) ? 2 : 0;
      kind = int'($urandom_range(0, 7));
      if (kind <= 4)      a = 12'(($urandom % 8) * 4);
      else if (kind == 5) a = 12'(($urandom % 8) * 4 + $urandom_range(1, 3));
      else if (kind == 6) a = 12'($urandom_range(8, 1023) * 4);
      else                a = 12'h01C;
      w    = 1'($urandom);
      drop = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, wc)) : -1;
      xfer(dsel, a, w, $urandom, 4'($urandom), drop, -1, rt, od, oe, ow, orr, oi, owd);
      gap = int'($urandom_range(0, 2));
      idle(gap);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
